// File: rtl/cordic_rot_iter_if.sv
// Operand/result bundle for the iterative CORDIC rotator.
// The master is the operand source, which also consumes results; the slave is the engine.
interface cordic_rot_iter_if #(
  parameter int WIDTH = 16
);
  logic                    start;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic signed [WIDTH-1:0] z_in;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] x_out;
  logic signed [WIDTH-1:0] y_out;
  logic signed [WIDTH-1:0] z_out;

  modport master (
    output start, x_in, y_in, z_in,
    input  busy, done, x_out, y_out, z_out
  );

  modport slave (
    input  start, x_in, y_in, z_in,
    output busy, done, x_out, y_out, z_out
  );
endinterface

// File: rtl/cordic_rot_iter.sv
// Iterative circular-mode CORDIC rotator: one micro-rotation per cycle, done ITERS+1 cycles after start.
// No backpressure: start is only honoured in IDLE, and results are held until the next done.
module cordic_rot_iter #(
  parameter int WIDTH  = 16,
  parameter int ITER_W = 4,
  parameter int ITERS  = 16
) (
  input  logic              clk,
  input  logic              sync_reset,
  cordic_rot_iter_if.slave  bus,
  input  logic [ITER_W-1:0] iter,
  output logic              cnt_load,
  output logic              cnt_count,
  output logic              cnt_up_down,
  output logic [ITER_W-1:0] cnt_N
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // atan(2^-i) with pi = 2^31; narrower widths keep the top WIDTH bits
  localparam logic [31:0] ATAN_TBL [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  state_t                  state;
  logic signed [WIDTH-1:0] x, y, z;
  logic signed [WIDTH-1:0] x_sh, y_sh, atan_w;
  logic signed [WIDTH-1:0] x_nxt, y_nxt, z_nxt;
  logic [4:0]              idx;
  logic                    last;

  assign idx         = 5'(iter);
  assign atan_w      = WIDTH'(ATAN_TBL[idx] >> (32 - WIDTH));
  assign last        = (iter == ITER_W'(ITERS - 1));
  assign cnt_up_down = 1'b0;
  assign cnt_N       = '0;
  assign cnt_load    = !sync_reset && (state == IDLE) && bus.start;
  assign cnt_count   = !sync_reset && (state == RUN) && !last;

  always_comb begin
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    if (!z[WIDTH-1]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atan_w;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atan_w;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state     <= IDLE;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      bus.x_out <= '0;
      bus.y_out <= '0;
      bus.z_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            x        <= bus.x_in;
            y        <= bus.y_in;
            z        <= bus.z_in;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          x <= x_nxt;
          y <= y_nxt;
          z <= z_nxt;
          // Final rotation lands directly in the result registers so they are valid with done
          if (last) begin
            bus.x_out <= x_nxt;
            bus.y_out <= y_nxt;
            bus.z_out <= z_nxt;
            bus.done  <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/cordic_rot_iter.md
Name: cordic_rot_iter

Overview:
- Iterative circular-mode CORDIC rotation engine: rotates the vector (x_in, y_in) by angle z_in over ITERS clock cycles, one micro-rotation per cycle.
- Directly drives the external binary up/down iteration counter (load, count, up_down, N) and consumes its count output as the iteration index, which sets the shift amount and the arctangent table address.
- Sits between the operand source (start/data) and the result consumer (done/x_out/y_out/z_out).

Parameters:
- WIDTH, 16, signed data and angle width; legal range 8..32.
- ITER_W, 4, iteration-counter width; must match the counter instance.
- ITERS, 16, micro-rotations per operation; 2 <= ITERS <= 2^ITER_W and ITERS <= WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- x_in  in  WIDTH  signed X operand.
- y_in  in  WIDTH  signed Y operand.
- z_in  in  WIDTH  signed angle; binary-angle format, 2^(WIDTH-1) = pi.
- iter  in  ITER_W  iteration index from the counter output.
- cnt_load  out  1  counter load strobe.
- cnt_count  out  1  counter count enable.
- cnt_up_down  out  1  counter direction; constant 0 (count up).
- cnt_N  out  ITER_W  counter load value; constant 0.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid.
- x_out, y_out, z_out  out  WIDTH each  signed results, held until the next done.

Behaviour:
- Reset: FSM=IDLE; busy, done, cnt_load, cnt_count = 0; x_out, y_out, z_out and internal x/y/z registers = 0. Reset mid-operation aborts immediately with no done pulse. The counter shares sync_reset.
- IDLE:
  - busy=0.
  - start=1: capture x_in/y_in/z_in into working registers, drive cnt_load=1 combinationally in the same cycle, next state RUN.
  - The counter therefore presents iter=0 in the first RUN cycle.
- RUN (busy=1), one micro-rotation per cycle using the current iter:
  - d = +1 if z >= 0, else -1.
  - x <= x - d*(y >>> iter); y <= y + d*(x >>> iter); z <= z - d*ATAN[iter].
  - >>> is an arithmetic shift; all arithmetic is WIDTH-bit two's complement, wrap with no saturation.
  - cnt_count=1 while iter != ITERS-1.
  - When iter == ITERS-1: cnt_count=0, last update performed, next state DONE.
- DONE: copy x, y, z into x_out, y_out, z_out; done=1 for exactly this cycle; busy=0; next state IDLE.
- Latency and throughput:
  - start sampled at edge E0; RUN occupies cycles 1..ITERS; done is high in cycle ITERS+1.
  - start during RUN or DONE is ignored. Minimum period between accepted starts is ITERS+2 cycles.
- ATAN table:
  - Entry i = round(atan(2^-i) * 2^31 / pi) as 32-bit constants, arithmetically shifted right by 32-WIDTH.
  - WIDTH=16 values: ATAN[0]=8192, ATAN[1]=4836.
- Gain: no compensation. Outputs are scaled by K ~ 1.64676, so callers pre-scale x_in by 0.60725.
- Operand limits: the caller keeps |z_in| <= 2^(WIDTH-2) (pi/2) and |x_in|, |y_in| < 0.6*2^(WIDTH-1). Out-of-range operands wrap silently; no error flag.
- cnt_load is high exactly one cycle per accepted operation. cnt_count is high exactly ITERS-1 cycles per operation.

Test Plan (WIDTH=16, ITERS=16, ITER_W=4):
- Rotate by +pi/4: x_in=9949, y_in=0, z_in=8192, start pulse -> done in cycle 17; x_out=11585±4, y_out=11585±4, |z_out| <= 4.
- Rotate by -pi/2: x_in=9949, y_in=0, z_in=-16384 -> |x_out| <= 4, y_out=-16384±4.
- Zero angle: x_in=9949, y_in=0, z_in=0 -> x_out=16384±4, |y_out| <= 4. Results stay held through 10 idle cycles.
- start held high continuously for 60 cycles -> done pulses every 18 cycles. Per operation: cnt_load high 1 cycle, cnt_count high 15 cycles, cnt_up_down=0, cnt_N=0 throughout.
- sync_reset asserted in the cycle where iter=7 -> next cycle: busy=0, done=0, outputs=0, FSM IDLE. No done follows. A subsequent start with the +pi/4 vector yields the first test's results.
- start pulse while busy with different operands -> ignored; the original operation's results are delivered unchanged.
